// File: rtl/rv32_pkg.sv
// Shared RV32 core constants, register/data typedefs and writeback source encoding.
package rv32_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 2 ** REG_AW;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for in-flight register destinations with a 3-port hazard lookup.
module rf_scoreboard
    import rv32_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            set_en_i,
    input  reg_addr_t       set_addr_i,
    input  logic            clr_en_i,
    input  reg_addr_t       clr_addr_i,
    input  reg_addr_t       rs1_i,
    input  reg_addr_t       rs2_i,
    input  reg_addr_t       rd_i,
    output logic            rs1_busy_o,
    output logic            rs2_busy_o,
    output logic            rd_busy_o,
    output logic [NREG-1:0] busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Set is applied after clear so a same-bit collision leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
        if (set_en_i) busy_d[set_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign rs1_busy_o = busy_q[rs1_i];
    assign rs2_busy_o = busy_q[rs2_i];
    assign rd_busy_o  = busy_q[rd_i];
    assign busy_o     = busy_q;

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port arbiter, write stage and issue hazard check.
// WB_RR_ARB_EN selects round-robin ALU/LSU arbitration; default is fixed LSU>ALU priority.
module rf_wb_scheduler
    import rv32_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            alu_valid,
    input  reg_addr_t       alu_rd,
    input  xlen_t           alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  reg_addr_t       lsu_rd,
    input  xlen_t           lsu_data,
    output logic            lsu_ready,
    input  logic            iss_valid,
    input  reg_addr_t       iss_rs1,
    input  reg_addr_t       iss_rs2,
    input  logic            iss_use_rs1,
    input  logic            iss_use_rs2,
    input  reg_addr_t       iss_rd,
    input  logic            iss_wr,
    output logic            iss_stall,
    output reg_addr_t       wa,
    output xlen_t           wda,
    output logic            reg_wr,
    output logic [NREG-1:0] busy,
    output logic            wb_err
);

    reg_addr_t wa_q, wa_d;
    xlen_t     wda_q, wda_d;
    logic      reg_wr_q, reg_wr_d;
    logic      wb_err_q, wb_err_d;

    logic      accept;
    wb_src_e   acc_src;
    reg_addr_t acc_rd;
    xlen_t     acc_data;
    logic      rs1_busy, rs2_busy, rd_busy;
    logic      iss_fire;

`ifdef WB_RR_ARB_EN
    wb_src_e   rr_last_q;

    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (alu_valid && lsu_valid) begin
            if (rr_last_q == WB_LSU) alu_ready = 1'b1;
            else                     lsu_ready = 1'b1;
        end else begin
            alu_ready = alu_valid;
            lsu_ready = lsu_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)      rr_last_q <= WB_ALU;
        else if (accept) rr_last_q <= acc_src;
    end
`else
    always_comb begin
        lsu_ready = lsu_valid;
        alu_ready = alu_valid && !lsu_valid;
    end
`endif

    assign accept   = alu_ready || lsu_ready;
    assign acc_src  = lsu_ready ? WB_LSU : WB_ALU;
    assign acc_rd   = (acc_src == WB_LSU) ? lsu_rd   : alu_rd;
    assign acc_data = (acc_src == WB_LSU) ? lsu_data : alu_data;

    always_comb begin
        wa_d     = wa_q;
        wda_d    = wda_q;
        reg_wr_d = 1'b0;
        wb_err_d = wb_err_q;
        if (accept) begin
            wa_d     = acc_rd;
            wda_d    = acc_data;
            reg_wr_d = (acc_rd != '0);
            // Writeback to an idle register is flagged but still performed.
            if ((acc_rd != '0) && !busy[acc_rd]) wb_err_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wa_q     <= '0;
            wda_q    <= '0;
            reg_wr_q <= 1'b0;
            wb_err_q <= 1'b0;
        end else begin
            wa_q     <= wa_d;
            wda_q    <= wda_d;
            reg_wr_q <= reg_wr_d;
            wb_err_q <= wb_err_d;
        end
    end

    assign iss_stall = iss_valid && ((iss_use_rs1 && rs1_busy) ||
                                     (iss_use_rs2 && rs2_busy) ||
                                     (iss_wr && rd_busy));
    assign iss_fire  = iss_valid && !iss_stall && iss_wr && (iss_rd != '0);

    rf_scoreboard u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .set_en_i   (iss_fire),
        .set_addr_i (iss_rd),
        .clr_en_i   (reg_wr_q),
        .clr_addr_i (wa_q),
        .rs1_i      (iss_rs1),
        .rs2_i      (iss_rs2),
        .rd_i       (iss_rd),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .rd_busy_o  (rd_busy),
        .busy_o     (busy)
    );

    assign wa     = wa_q;
    assign wda    = wda_q;
    assign reg_wr = reg_wr_q;
    assign wb_err = wb_err_q;

endmodule
